// File: rtl/lut_mem_access_if.sv
// lut_mem_access_if: core-side request/response bundle of the load/store
// sequencer.
//   req_valid / req_ready : request handshake
//   req_write             : 1 = store, 0 = load
//   req_idx               : address-table index
//   req_wdata             : store data
//   rsp_valid / rsp_ready : response handshake
//   rsp_rdata             : load result
//   rsp_err               : request rejected
// Modports: master = core, slave = sequencer.
interface lut_mem_access_if #(
  parameter int unsigned IDX_W = 5,
  parameter int unsigned DW    = 8
);
  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  logic [IDX_W-1:0] req_idx;
  logic [DW-1:0]    req_wdata;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [DW-1:0]    rsp_rdata;
  logic             rsp_err;

  modport master (
    output req_valid, req_write, req_idx, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_idx, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/lut_mem_access.sv
// lut_mem_access: load/store sequencer. Resolves a core index through a
// combinational address LUT, performs one access on a synchronous data
// memory and returns a valid/ready response.
// Ports:
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   core        : request/response bundle (lut_mem_access_if.slave)
//   lut_addr    : index to the LUT (latched request index)
//   lut_data    : address from the LUT, combinational
//   mem_addr    : data-memory address (registered LUT result)
//   mem_we      : write strobe, mem_wdata write data
//   mem_re      : read strobe, mem_rdata valid the cycle after
// Option macro LUT_IDX_CHECK_EN: indices in the upper half of the table are
// unpopulated and answered directly with rsp_err=1, no memory access.
module lut_mem_access #(
  parameter int unsigned IDX_W = 5,
  parameter int unsigned DW    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  lut_mem_access_if.slave  core,
  output logic [IDX_W-1:0] lut_addr,
  input  logic [DW-1:0]    lut_data,
  output logic [DW-1:0]    mem_addr,
  output logic             mem_we,
  output logic             mem_re,
  output logic [DW-1:0]    mem_wdata,
  input  logic [DW-1:0]    mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    ACCESS,
    WAIT,
    RESP
  } state_t;

  state_t state;
  logic   write_q;

`ifndef LUT_IDX_CHECK_EN
  assign core.rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      write_q        <= 1'b0;
      lut_addr       <= '0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_we         <= 1'b0;
      mem_re         <= 1'b0;
      core.req_ready <= 1'b1;
      core.rsp_valid <= 1'b0;
      core.rsp_rdata <= '0;
`ifdef LUT_IDX_CHECK_EN
      core.rsp_err   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (core.req_valid) begin
            write_q        <= core.req_write;
            lut_addr       <= core.req_idx;
            mem_wdata      <= core.req_wdata;
            core.req_ready <= 1'b0;
`ifdef LUT_IDX_CHECK_EN
            // Upper half of the table is unpopulated: answer at once.
            if (core.req_idx[IDX_W-1]) begin
              core.rsp_valid <= 1'b1;
              core.rsp_err   <= 1'b1;
              state          <= RESP;
            end else begin
              state <= LOOKUP;
            end
`else
            state <= LOOKUP;
`endif
          end
        end
        LOOKUP: begin
          // Registered LUT result drives the memory during ACCESS.
          mem_addr <= lut_data;
          mem_we   <= write_q;
          mem_re   <= ~write_q;
          state    <= ACCESS;
        end
        ACCESS: begin
          mem_we <= 1'b0;
          mem_re <= 1'b0;
          if (write_q) begin
            core.rsp_valid <= 1'b1;
            state          <= RESP;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          core.rsp_rdata <= mem_rdata;
          core.rsp_valid <= 1'b1;
          state          <= RESP;
        end
        RESP: begin
          if (core.rsp_ready) begin
            core.rsp_valid <= 1'b0;
            core.req_ready <= 1'b1;
`ifdef LUT_IDX_CHECK_EN
            core.rsp_err   <= 1'b0;
`endif
            state          <= IDLE;
          end
        end
        default: begin
          mem_we         <= 1'b0;
          mem_re         <= 1'b0;
          core.rsp_valid <= 1'b0;
          core.req_ready <= 1'b1;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lut_mem_access.sv
// tb_lut_mem_access: directed test of lut_mem_access with a LUT model and a
// synchronous 256x8 memory model. Covers reset, store, load, backpressure,
// back-to-back access, the idx=20 case and reset during ACCESS.
module tb_lut_mem_access;
  logic       clk;
  logic       rst_n;
  logic [4:0] lut_addr;
  logic [7:0] lut_data;
  logic [7:0] mem_addr;
  logic       mem_we;
  logic       mem_re;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  int n_checks;
  int n_pass;

  lut_mem_access_if #(.IDX_W(5), .DW(8)) bus ();

  lut_mem_access #(.IDX_W(5), .DW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .core      (bus),
    .lut_addr  (lut_addr),
    .lut_data  (lut_data),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // LUT model: two fixed entries, every other index maps to idx+100.
  always_comb begin
    case (lut_addr)
      5'd3:    lut_data = 8'd63;
      5'd10:   lut_data = 8'd70;
      default: lut_data = 8'(lut_addr) + 8'd100;
    endcase
  end

  logic [7:0] mem [256] = '{70: 8'h3C, 120: 8'h5A, default: 8'h00};

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.req_ready && n < 50) begin
      tick();
      n++;
    end
    check("ready_timeout", bus.req_ready, 1);
  endtask

  task automatic drive(input logic wr, input logic [4:0] idx, input logic [7:0] wd);
    bus.req_write = wr;
    bus.req_idx   = idx;
    bus.req_wdata = wd;
    bus.req_valid = 1'b1;
  endtask

  task automatic check_reset(input string p);
    check({p, "_req_ready"}, bus.req_ready, 1);
    check({p, "_rsp_valid"}, bus.rsp_valid, 0);
    check({p, "_rsp_err"},   bus.rsp_err, 0);
    check({p, "_rsp_rdata"}, bus.rsp_rdata, 0);
    check({p, "_mem_we"},    mem_we, 0);
    check({p, "_mem_re"},    mem_re, 0);
    check({p, "_mem_addr"},  mem_addr, 0);
    check({p, "_mem_wdata"}, mem_wdata, 0);
    check({p, "_lut_addr"},  lut_addr, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    n_checks = 0;
    n_pass   = 0;
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_idx   = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    #12;
    check_reset("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Store idx=3 -> addr 63, data 0xA5
    wait_ready();
    drive(1'b1, 5'd3, 8'hA5);
    tick();
    bus.req_valid = 1'b0;
    check("st_lut_addr", lut_addr, 3);
    check("st_c1_we", mem_we, 0);
    tick();
    check("st_c2_we", mem_we, 1);
    check("st_c2_re", mem_re, 0);
    check("st_c2_addr", mem_addr, 63);
    check("st_c2_wdata", mem_wdata, 8'hA5);
    check("st_c2_valid", bus.rsp_valid, 0);
    tick();
    check("st_c3_we", mem_we, 0);
    check("st_c3_valid", bus.rsp_valid, 1);
    check("st_c3_err", bus.rsp_err, 0);
    check("st_c3_ready", bus.req_ready, 0);
    tick();
    check("st_c4_valid", bus.rsp_valid, 0);
    check("st_c4_ready", bus.req_ready, 1);

    // Load idx=10 -> addr 70, memory holds 0x3C
    wait_ready();
    drive(1'b0, 5'd10, 8'h00);
    tick();
    bus.req_valid = 1'b0;
    tick();
    check("ld_c2_re", mem_re, 1);
    check("ld_c2_we", mem_we, 0);
    check("ld_c2_addr", mem_addr, 70);
    tick();
    check("ld_c3_re", mem_re, 0);
    check("ld_c3_valid", bus.rsp_valid, 0);
    tick();
    check("ld_c4_valid", bus.rsp_valid, 1);
    check("ld_c4_rdata", bus.rsp_rdata, 8'h3C);
    tick();
    check("ld_c5_ready", bus.req_ready, 1);

    // Backpressure: load idx=3 (0xA5), next request held valid throughout
    wait_ready();
    bus.rsp_ready = 1'b0;
    drive(1'b0, 5'd3, 8'h00);
    tick();
    drive(1'b1, 5'd5, 8'h77);
    tick();
    tick();
    tick();
    check("bp_valid0", bus.rsp_valid, 1);
    check("bp_rdata0", bus.rsp_rdata, 8'hA5);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("bp_valid", bus.rsp_valid, 1);
      check("bp_rdata", bus.rsp_rdata, 8'hA5);
      check("bp_req_ready", bus.req_ready, 0);
      check("bp_strobes", {mem_we, mem_re}, 0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    check("bp_rel_ready", bus.req_ready, 1);
    check("bp_rel_valid", bus.rsp_valid, 0);
    tick();
    bus.req_valid = 1'b0;
    check("bp_acc_ready", bus.req_ready, 0);
    check("bp_acc_lut", lut_addr, 5);
    tick();
    check("bp_st_we", mem_we, 1);
    check("bp_st_addr", mem_addr, 105);
    check("bp_st_wdata", mem_wdata, 8'h77);
    tick();
    check("bp_st_valid", bus.rsp_valid, 1);
    tick();

    // Back-to-back: store idx=0 0x11 then load idx=0
    wait_ready();
    drive(1'b1, 5'd0, 8'h11);
    tick();
    drive(1'b0, 5'd0, 8'h00);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.req_ready && n < 20);
    check("b2b_spacing", n + 1, 4);
    tick();
    bus.req_valid = 1'b0;
    tick();
    tick();
    tick();
    check("b2b_ld_valid", bus.rsp_valid, 1);
    check("b2b_ld_rdata", bus.rsp_rdata, 8'h11);
    tick();

    // idx=20
    wait_ready();
    drive(1'b0, 5'd20, 8'h00);
    tick();
    bus.req_valid = 1'b0;
`ifdef LUT_IDX_CHECK_EN
    check("chk_valid", bus.rsp_valid, 1);
    check("chk_err", bus.rsp_err, 1);
    check("chk_rdata", bus.rsp_rdata, 8'h11);
    check("chk_strobes", {mem_we, mem_re}, 0);
    tick();
    check("chk_done_valid", bus.rsp_valid, 0);
    check("chk_done_err", bus.rsp_err, 0);
    check("chk_done_ready", bus.req_ready, 1);
    check("chk_done_strobes", {mem_we, mem_re}, 0);
`else
    check("i20_valid1", bus.rsp_valid, 0);
    check("i20_lut", lut_addr, 20);
    tick();
    check("i20_re", mem_re, 1);
    check("i20_addr", mem_addr, 120);
    tick();
    tick();
    check("i20_valid", bus.rsp_valid, 1);
    check("i20_err", bus.rsp_err, 0);
    check("i20_rdata", bus.rsp_rdata, 8'h5A);
    tick();
`endif

    // Reset asserted mid-cycle while a load is in ACCESS
    wait_ready();
    drive(1'b0, 5'd10, 8'h00);
    tick();
    bus.req_valid = 1'b0;
    tick();
    check("rst_pre_re", mem_re, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rst_post_ready", bus.req_ready, 1);
    check("rst_post_valid", bus.rsp_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
